exprom_read_ctrl: RTL and testbench

//  PCI expansion-ROM read controller: consumes the four 512x8 byte-lane option-ROM blocks (rom0..rom3),

---
 rtl/exprom_pkg.sv | 22 ++
 rtl/exprom_rsp_fifo.sv | 51 +++++
 rtl/exprom_read_ctrl.sv | 139 +++++++++++++
 tb/tb_exprom_read_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exprom_pkg.sv
// Shared constants and types for the expansion-ROM read controller.
package exprom_pkg;

  localparam int          ROM_AW    = 9;
  localparam int          ROM_BYTES = 2048;
  localparam logic [31:0] ERR_DATA  = 32'hFFFF_FFFF;

  // Controller sequencing: wait for a request, issue reads, wait for the last beat to leave.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One response beat as held in the output buffer.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

endpackage

// File: rtl/exprom_rsp_fifo.sv
// Two-entry response buffer. The head entry drives the response channel directly,
// so its contents stay put until it is popped.
module exprom_rsp_fifo
  import exprom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      din,
  input  logic       pop,
  output beat_t      dout,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  push_ok;
  logic  pop_ok;

  // Ignore a pop when empty and a push when full unless a pop frees a slot.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/exprom_read_ctrl.sv
// Expansion-ROM read controller: decodes the ROM BAR window, walks the four byte lanes
// one dword per cycle, absorbs the one-cycle lane read latency and returns dword bursts.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// A source holds valid and its payload steady until that edge; ready may change freely.
module exprom_read_ctrl
  import exprom_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rom_bar_en,
  input  logic [29-ROM_AW:0]   rom_base,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic [LEN_W-1:0]     req_len,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_last,
  output logic                 rsp_err,
  output logic [ROM_AW-1:0]    rom_addr,
  output logic                 rom_en,
  output logic                 rom_wren,
  output logic [7:0]           rom_dinp,
  input  logic [7:0]           rom0_dout,
  input  logic [7:0]           rom1_dout,
  input  logic [7:0]           rom2_dout,
  input  logic [7:0]           rom3_dout,
  output logic                 busy,
  output state_t               dbg_state
);

  state_t             state;
  logic               hit_q;
  logic [ROM_AW-1:0]  ptr;
  logic [LEN_W-1:0]   remaining;
  logic               infl;
  logic               infl_last;
  logic               infl_err;

  logic               req_hit;
  logic               pop;
  logic               issue;
  logic               room;
  logic [2:0]         occ;
  logic [1:0]         count;
  beat_t              head;
  beat_t              push_beat;
  logic               unused_addr_lsb;

  // Byte offset within the dword is irrelevant to a dword-wide ROM.
  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_hit = rom_bar_en && (req_addr[31:ROM_AW+2] == rom_base);

  assign rsp_valid = (count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;

  // A new issue must still have a slot when its data lands next cycle. A slot freed by a
  // pop this cycle counts, but a full buffer never issues.
  assign occ   = {1'b0, count} + {2'b00, infl};
  assign room  = (count != 2'd2) && ((occ - {2'b00, pop}) < 3'd2);
  assign issue = (state == ST_RUN) && room;

  // Out-of-window bursts go through the same issue/latency path with the lanes left idle.
  assign rom_en   = issue && hit_q;
  assign rom_addr = ptr;
  assign rom_wren = 1'b0;
  assign rom_dinp = 8'h00;

  // rom3 carries byte 0, rom0 carries byte 3.
  assign push_beat.data = infl_err ? ERR_DATA : {rom0_dout, rom1_dout, rom2_dout, rom3_dout};
  assign push_beat.last = infl_last;
  assign push_beat.err  = infl_err;

  exprom_rsp_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign rsp_data  = head.data;
  assign rsp_last  = head.last;
  assign rsp_err   = head.err;
  assign req_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Request decode, burst sequencing and the one-deep in-flight tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hit_q     <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      infl_err  <= 1'b0;
    end else begin
      infl      <= issue;
      infl_last <= issue && (remaining == '0);
      infl_err  <= issue && !hit_q;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            hit_q     <= req_hit;
            ptr       <= req_addr[ROM_AW+1:2];
            remaining <= req_len;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            ptr <= ptr + 1'b1;
            if (remaining == '0) begin
              state <= ST_DRAIN;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head.last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exprom_read_ctrl.sv
// Bench for exprom_read_ctrl: lane BRAM models, request driver, response scoreboard.
module tb_exprom_read_ctrl;
  import exprom_pkg::*;

  localparam int W = 34;  // {err, last, data}

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_bar_en;
  logic [20:0] rom_base;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic [8:0]  rom_addr;
  logic        rom_en;
  logic        rom_wren;
  logic [7:0]  rom_dinp;
  logic [7:0]  rom0_dout, rom1_dout, rom2_dout, rom3_dout;
  logic        busy;
  state_t      dbg_state;

  exprom_read_ctrl dut (
    .clk(clk), .rst(rst), .rom_bar_en(rom_bar_en), .rom_base(rom_base),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_wren(rom_wren), .rom_dinp(rom_dinp), .rom0_dout(rom0_dout), .rom1_dout(rom1_dout),
    .rom2_dout(rom2_dout), .rom3_dout(rom3_dout), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- lane images and synchronous-read BRAM models ----------------
  logic [7:0] img0 [512];
  logic [7:0] img1 [512];
  logic [7:0] img2 [512];
  logic [7:0] img3 [512];

  always @(posedge clk) begin
    if (rom_en) begin
      rom0_dout <= img0[rom_addr];
      rom1_dout <= img1[rom_addr];
      rom2_dout <= img2[rom_addr];
      rom3_dout <= img3[rom_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int  pops_seen = 0;
  int  en_seen   = 0;
  bit  ready_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: beat i of a burst starting at addr is the dword (start+i) mod 512 of the
  // ROM image, bytes taken lane0..lane3 from MSB to LSB, or the error pattern on a miss.
  function automatic logic [W-1:0] model_beat(input bit en, input logic [20:0] base,
                                               input logic [31:0] addr, input int i,
                                               input int len);
    int   d;
    logic [8:0] dw;
    logic last;
    last = (i == len);
    if (en && (addr[31:11] == base)) begin
      d  = (int'(addr[10:2]) + i) % 512;
      dw = d[8:0];
      return {1'b0, last, img0[dw], img1[dw], img2[dw], img3[dw]};
    end
    return {1'b1, last, 32'hFFFF_FFFF};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] addr, input int len, output int waits);
    for (int i = 0; i <= len; i++) exp_q.push_back(model_beat(rom_bar_en, rom_base, addr, i, len));
    req_addr  = addr;
    req_len   = 4'(len);
    req_valid = 1'b1;
    waits     = 0;
    while (!req_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) check("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int n, output int first_v);
    n = 0;
    first_v = 0;
    do begin
      @(negedge clk);
      n++;
      if (rsp_valid && first_v == 0) first_v = n;
    end while (busy && n < 400);
    check("burst_done", 64'(busy), 64'd0);
  endtask

  // ---------------- response readiness ----------------
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = ready_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  logic [W-1:0] hold_v;
  bit           hold;
  int           issued, popped, held;
  bit           en_prev;

  initial begin
    hold = 0; issued = 0; popped = 0; en_prev = 0; hold_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; issued = 0; popped = 0; en_prev = 0;
      end else begin
        if (hold) check("hold_stable", {rsp_valid, rsp_err, rsp_last, rsp_data}, {1'b1, hold_v});
        if (busy) check("ready_while_busy", 64'(req_ready), 64'd0);
        if (rom_en) begin
          held = issued - popped - int'(en_prev);
          check("issue_with_room", 64'(held < 2), 64'd1);
          en_seen++;
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %0h want none", {rsp_err, rsp_last, rsp_data});
          end else begin
            mon_e = exp_q.pop_front();
            check("beat", {rsp_err, rsp_last, rsp_data}, mon_e);
          end
          pops_seen++;
          if (!rsp_err) popped++;
        end
        hold    = rsp_valid && !rsp_ready;
        hold_v  = {rsp_err, rsp_last, rsp_data};
        issued += int'(rom_en);
        en_prev = rom_en;
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] BASE_ADDR = 32'h000F_0000;
  int waits, n, first_v, en_before, start_pops, len;
  logic [31:0] addr;

  initial begin
    for (int i = 0; i < 512; i++) begin
      img0[i] = 8'($urandom);
      img1[i] = 8'($urandom);
      img2[i] = 8'($urandom);
      img3[i] = 8'($urandom);
    end
    img0[0] = 8'hEB; img1[0] = 8'h00; img2[0] = 8'h04; img3[0] = 8'hAA;
    rom0_dout = '0; rom1_dout = '0; rom2_dout = '0; rom3_dout = '0;

    rst = 1'b1;
    rom_bar_en = 1'b1;
    rom_base   = BASE_ADDR[31:11];
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rom_en", 64'(rom_en), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_rsp_fields", {rsp_data, rsp_last, rsp_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Single dword at the window base.
    send(BASE_ADDR, 0, waits);
    wait_done(n, first_v);
    check("single_latency", 64'(first_v), 64'd3);
    check("single_cycles", 64'(n), 64'd4);

    // Wrapping 16-beat burst at full throughput.
    send(BASE_ADDR + 32'(504 * 4), 15, waits);
    wait_done(n, first_v);
    check("burst_latency", 64'(first_v), 64'd3);
    check("burst_cycles", 64'(n), 64'd19);

    // Same burst under backpressure.
    ready_rand = 1'b1;
    send(BASE_ADDR + 32'(504 * 4), 15, waits);
    wait_done(n, first_v);
    ready_rand = 1'b0;
    @(negedge clk);

    // BAR disabled: error beats, lanes untouched.
    rom_bar_en = 1'b0;
    en_before  = en_seen;
    send(BASE_ADDR + 32'h40, 3, waits);
    wait_done(n, first_v);
    check("miss_cycles", 64'(n), 64'd7);
    check("miss_no_rom_en", 64'(en_seen), 64'(en_before));
    rom_bar_en = 1'b1;

    // BAR enabled but address outside the window.
    en_before = en_seen;
    send(32'h0010_0000, 1, waits);
    wait_done(n, first_v);
    check("window_miss_no_rom_en", 64'(en_seen), 64'(en_before));

    // Reset in the middle of a burst.
    start_pops = pops_seen;
    send(BASE_ADDR + 32'h100, 15, waits);
    for (int i = 0; i < 50 && pops_seen < start_pops + 4; i++) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(BASE_ADDR + 32'h20, 2, waits);
    wait_done(n, first_v);
    check("after_rst_cycles", 64'(n), 64'd6);

    // Back-to-back requests with valid held.
    send(BASE_ADDR + 32'h300, 5, waits);
    send(BASE_ADDR + 32'h7F8, 2, waits);
    check("b2b_accept_wait", 64'(waits), 64'd9);
    wait_done(n, first_v);

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      ready_rand = ($urandom_range(0, 1) == 1);
      rom_bar_en = ($urandom_range(0, 9) != 0);
      len        = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0) addr = $urandom;
      else addr = {BASE_ADDR[31:11], 11'($urandom)};
      send(addr, len, waits);
      if ($urandom_range(0, 1) == 1) wait_done(n, first_v);
    end
    wait_done(n, first_v);
    ready_rand = 1'b0;
    repeat (4) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("rom_wren_zero", 64'(rom_wren), 64'd0);
    check("rom_dinp_zero", 64'(rom_dinp), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
